// File: rtl/clk_strobe_gen.sv
// clk_strobe_gen: programmable clock-enable strobe generator.
// Divides clk by a runtime-loadable ratio and emits a one-cycle strobe per period,
// with a load/ack handshake that swaps the divisor only on a period boundary.
// Optional divided clock output enabled by macro CLK_STROBE_GEN_DIVCLK_EN.
module clk_strobe_gen #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             strobe,
  output logic [15:0]      strobe_cnt,
  output logic             clk_div
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_reg_q, div_reg_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             strobe_q, strobe_d;
  logic             div_ack_q, div_ack_d;
  logic [15:0]      strobe_cnt_q, strobe_cnt_d;

  logic [CNT_W-1:0] last_cnt;
  logic             wrap;
  logic             apply;

  // Period counter, divisor handshake and strobe accounting.
  always_comb begin
    cnt_d        = cnt_q;
    div_reg_d    = div_reg_q;
    pend_val_d   = pend_val_q;
    pend_d       = pend_q;
    strobe_d     = 1'b0;
    div_ack_d    = 1'b0;
    strobe_cnt_d = strobe_cnt_q;

    // Divisors 0 and 1 both mean "strobe every enabled cycle".
    last_cnt = (div_reg_q <= ONE) ? '0 : div_reg_q - ONE;
    wrap     = en && (cnt_q == last_cnt);
    // A load arriving in this edge takes over the pending slot and defers the
    // apply, so back-to-back loads yield one ack carrying the latest value.
    apply    = pend_q && !div_load && (wrap || !en);

    if (en) begin
      if (wrap) begin
        cnt_d        = '0;
        strobe_d     = 1'b1;
        strobe_cnt_d = strobe_cnt_q + 16'd1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else if (apply) begin
      cnt_d = '0;
    end

    if (apply) begin
      div_reg_d = pend_val_q;
      pend_d    = 1'b0;
      div_ack_d = 1'b1;
    end

    if (div_load) begin
      pend_val_d = div_in;
      pend_d     = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      div_reg_q    <= CNT_W'(DEFAULT_DIV);
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      strobe_q     <= 1'b0;
      div_ack_q    <= 1'b0;
      strobe_cnt_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      div_reg_q    <= div_reg_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      strobe_q     <= strobe_d;
      div_ack_q    <= div_ack_d;
      strobe_cnt_q <= strobe_cnt_d;
    end
  end

  assign strobe     = strobe_q;
  assign div_ack    = div_ack_q;
  assign strobe_cnt = strobe_cnt_q;

`ifdef CLK_STROBE_GEN_DIVCLK_EN
  logic clk_div_q, clk_div_d;

  // Divided clock toggles on every wrap edge: period 2*N_eff, 50% duty.
  always_comb begin
    clk_div_d = clk_div_q ^ wrap;
  end

  // Divided clock register.
  always_ff @(posedge clk) begin
    if (rst) clk_div_q <= 1'b0;
    else     clk_div_q <= clk_div_d;
  end

  assign clk_div = clk_div_q;
`else
  assign clk_div = 1'b0;
`endif

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Self-checking bench for clk_strobe_gen: directed scenarios plus a random
// phase, compared every cycle against a behavioural model of the divider rules.
module tb_clk_strobe_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_in;
  logic        div_load;
  logic        div_ack;
  logic        strobe;
  logic [15:0] strobe_cnt;
  logic        clk_div;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int m_cnt, m_div, m_pv, m_pend, m_strobe, m_ack, m_scnt, m_clk;
  int ack_seen;

  clk_strobe_gen #(.CNT_W(16), .DEFAULT_DIV(10)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .div_ack(div_ack), .strobe(strobe), .strobe_cnt(strobe_cnt), .clk_div(clk_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge of the model, using the inputs currently applied.
  task automatic model_step();
    int period;
    bit wrap, apply;
    if (rst) begin
      m_cnt = 0; m_div = 10; m_pv = 0; m_pend = 0;
      m_strobe = 0; m_ack = 0; m_scnt = 0; m_clk = 0;
    end else begin
      period = (m_div < 2) ? 1 : m_div;
      wrap   = en && (m_cnt == period - 1);
      apply  = (m_pend != 0) && !div_load && (wrap || !en);
      m_strobe = wrap;
      m_ack    = apply;
      if (wrap) begin
        m_scnt = (m_scnt + 1) % 65536;
        m_clk  = 1 - m_clk;
      end
      if (en) m_cnt = wrap ? 0 : m_cnt + 1;
      else if (apply) m_cnt = 0;
      if (apply) begin
        m_div  = m_pv;
        m_pend = 0;
      end
      if (div_load) begin
        m_pv   = div_in;
        m_pend = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    if (div_ack === 1'b1) ack_seen++;
    chk("strobe", 16'(strobe), 16'(m_strobe));
    chk("div_ack", 16'(div_ack), 16'(m_ack));
    chk("strobe_cnt", strobe_cnt, 16'(m_scnt));
`ifdef CLK_STROBE_GEN_DIVCLK_EN
    chk("clk_div", 16'(clk_div), 16'(m_clk));
`else
    chk("clk_div", 16'(clk_div), 16'd0);
`endif
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic load(input int v);
    div_in   = 16'(v);
    div_load = 1'b1;
    cycle();
    div_load = 1'b0;
  endtask

  initial begin
    int first;
    int guard;

    rst = 1'b1; en = 1'b0; div_in = '0; div_load = 1'b0;
    m_cnt = 0; m_div = 10; m_pv = 0; m_pend = 0;
    m_strobe = 0; m_ack = 0; m_scnt = 0; m_clk = 0; ack_seen = 0;
    run(2);
    chk("rst_strobe", 16'(strobe), 16'd0);
    chk("rst_scnt", strobe_cnt, 16'd0);
    chk("rst_ack", 16'(div_ack), 16'd0);
    chk("rst_clkdiv", 16'(clk_div), 16'd0);

    // Default divisor 10: first strobe after edge 10, three after 30 edges.
    rst = 1'b0; en = 1'b1; first = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (strobe === 1'b1 && first == 0) first = i;
    end
    chk("first_strobe", 16'(first), 16'd10);
    chk("scnt_after_30", strobe_cnt, 16'd3);

    // Load 4 three cycles into a period; ack lands on the period-10 strobe.
    run(2);
    ack_seen = 0;
    load(4);
    run(7);
    chk("ack_on_wrap", 16'(div_ack), 16'd1);
    chk("strobe_with_ack", 16'(strobe), 16'd1);
    run(12);
    chk("ack_count_4", 16'(ack_seen), 16'd1);

    // Divisors 0 and 1: continuous strobe.
    load(0);
    run(8);
    chk("div0_strobe", 16'(strobe), 16'd1);
    load(1);
    run(6);
    chk("div1_strobe", 16'(strobe), 16'd1);

    // N=5, freeze at cnt=2 for 7 cycles, then resume.
    load(5);
    run(6);
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("reach_cnt2", 16'(m_cnt), 16'd2);
    en = 1'b0;
    run(7);
    en = 1'b1; first = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (strobe === 1'b1 && first == 0) first = i;
    end
    chk("resume_strobe", 16'(first), 16'd3);

    // Back-to-back loads 6 then 8 produce a single ack.
    ack_seen = 0;
    load(6);
    load(8);
    run(20);
    chk("single_ack", 16'(ack_seen), 16'd1);
    run(10);

    // Reset during a pending load discards it without an ack.
    load(7);
    rst = 1'b1;
    cycle();
    chk("rstp_strobe", 16'(strobe), 16'd0);
    chk("rstp_scnt", strobe_cnt, 16'd0);
    chk("rstp_ack", 16'(div_ack), 16'd0);
    chk("rstp_clkdiv", 16'(clk_div), 16'd0);
    rst = 1'b0; ack_seen = 0;
    run(30);
    chk("rstp_no_ack", 16'(ack_seen), 16'd0);
    chk("rstp_default", strobe_cnt, 16'd3);

    // Divisor applied while disabled, then N=3 for the divided clock.
    en = 1'b0;
    load(3);
    run(2);
    en = 1'b1;
    run(24);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 399) == 0);
      en       = ($urandom_range(0, 9) < 8);
      div_load = ($urandom_range(0, 19) == 0);
      div_in   = 16'($urandom_range(0, 12));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
